// File: rtl/ptr_sync_multi_if.sv
// -----------------------------------------------------------------------------
// ptr_sync_multi_if
// Bundles the pointer-synchroniser signals into a single port.
//   master : pointer source / status consumer (drives ptr_in, err_clr)
//   slave  : the synchroniser itself (drives everything else)
// Signals:
//   ptr_in        Gray pointer from the foreign clock domain
//   err_clr       synchronous clear of gray_err / err_count
//   ptr_sync_gray synchronised Gray pointer
//   ptr_sync_bin  registered binary form of ptr_sync_gray
//   ptr_valid     pipeline holds post-reset samples only
//   ptr_changed   one-cycle pulse per new ptr_sync_bin value
//   gray_err      sticky Gray-integrity violation flag
//   err_count     saturating Gray-violation counter
// -----------------------------------------------------------------------------
interface ptr_sync_multi_if #(
    parameter int A_WIDTH   = 4,
    parameter int ERR_CNT_W = 8
);
    logic [A_WIDTH:0]   ptr_in;
    logic               err_clr;
    logic [A_WIDTH:0]   ptr_sync_gray;
    logic [A_WIDTH:0]   ptr_sync_bin;
    logic               ptr_valid;
    logic               ptr_changed;
    logic               gray_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output ptr_in, err_clr,
        input  ptr_sync_gray, ptr_sync_bin, ptr_valid, ptr_changed, gray_err, err_count
    );

    modport slave (
        input  ptr_in, err_clr,
        output ptr_sync_gray, ptr_sync_bin, ptr_valid, ptr_changed, gray_err, err_count
    );
endinterface

// File: rtl/ptr_sync_multi.sv
// -----------------------------------------------------------------------------
// ptr_sync_multi
// Brings a Gray-coded async-FIFO pointer into the Clk domain through
// SYNC_STAGES flops (legal range 2..4), then provides a registered binary
// copy, a change pulse, a warm-up valid flag and Gray-integrity checking
// (sticky flag plus saturating counter).
// Ports:
//   Clk    destination clock, rising edge
//   Reset  synchronous active-high reset (wins over everything, incl. err_clr)
//   bus    ptr_sync_multi_if.slave (see interface file for signal list)
// -----------------------------------------------------------------------------
module ptr_sync_multi #(
    parameter int A_WIDTH     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    ptr_sync_multi_if.slave   bus
);
    localparam int P_W    = A_WIDTH + 1;
    localparam int WCNT_W = $clog2(SYNC_STAGES + 2);
    // Warm-up count at which every stage, prev_gray and the binary copy
    // have been refilled from post-reset samples.
    localparam logic [WCNT_W-1:0] WARM_DONE = WCNT_W'(SYNC_STAGES + 1);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [P_W-1:0] gray2bin(input logic [P_W-1:0] g);
        logic [P_W-1:0] b;
        b[P_W-1] = g[P_W-1];
        for (int i = P_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when a difference vector has two or more set bits.
    function automatic logic multi_bit_diff(input logic [P_W-1:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < P_W; i++) begin
            ones = ones + int'(d[i]);
        end
        return (ones > 1);
    endfunction

    logic [P_W-1:0]       stage_r [SYNC_STAGES];
    logic [P_W-1:0]       prev_gray_r;
    logic [P_W-1:0]       bin_r;
    logic [WCNT_W-1:0]    warm_cnt_r;
    logic                 valid_r;
    logic                 changed_r;
    logic                 err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    logic [P_W-1:0]       gray_s;
    logic                 viol_s;
    logic                 change_s;

    assign gray_s = stage_r[SYNC_STAGES-1];

    // Change / violation detection on the synchronised value, gated by warm-up.
    always_comb begin
        viol_s   = 1'b0;
        change_s = 1'b0;
        if (valid_r) begin
            viol_s   = multi_bit_diff(gray_s ^ prev_gray_r);
            change_s = (gray_s != prev_gray_r);
        end else begin
            viol_s   = 1'b0;
            change_s = 1'b0;
        end
    end

    // Sync chain, binary copy, warm-up counter and error bookkeeping.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                stage_r[k] <= '0;
            end
            prev_gray_r <= '0;
            bin_r       <= '0;
            warm_cnt_r  <= '0;
            valid_r     <= 1'b0;
            changed_r   <= 1'b0;
            err_r       <= 1'b0;
            err_cnt_r   <= '0;
        end else begin
            stage_r[0] <= bus.ptr_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
            prev_gray_r <= gray_s;
            bin_r       <= gray2bin(gray_s);
            // A change in the Gray value is exactly a change in the binary copy.
            changed_r   <= change_s;

            if (warm_cnt_r != WARM_DONE) begin
                warm_cnt_r <= warm_cnt_r + WCNT_W'(1);
            end else begin
                warm_cnt_r <= warm_cnt_r;
            end
            valid_r <= (warm_cnt_r == WARM_DONE);

            // A clear in the same cycle as a violation discards the violation.
            if (bus.err_clr) begin
                err_r     <= 1'b0;
                err_cnt_r <= '0;
            end else if (viol_s) begin
                err_r <= 1'b1;
                if (err_cnt_r != {ERR_CNT_W{1'b1}}) begin
                    err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
                end else begin
                    err_cnt_r <= err_cnt_r;
                end
            end else begin
                err_r     <= err_r;
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign bus.ptr_sync_gray = gray_s;
    assign bus.ptr_sync_bin  = bin_r;
    assign bus.ptr_valid     = valid_r;
    assign bus.ptr_changed   = changed_r;
    assign bus.gray_err      = err_r;
    assign bus.err_count     = err_cnt_r;

endmodule
